// File: rtl/sdram_axi_memtest.sv
// AXI4 master memory tester: writes a pattern region in INCR bursts, reads it back, counts errors.
// Optional MEMTEST_LFSR_EN selects a 32-bit Galois LFSR pattern instead of address XOR key.
module sdram_axi_memtest #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          NUM_BURSTS = 64,
  parameter int          BURST_LEN  = 16,
  parameter logic [3:0]  AXI_ID     = 4'h3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [3:0]  awid,
  output logic [7:0]  awlen,
  output logic [1:0]  awburst,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  input  logic [3:0]  bid,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic [3:0]  rid,
  input  logic        rlast
);

  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [31:0] XOR_KEY     = 32'hA5A5_5A5A;

  typedef enum logic [2:0] {IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, FIN} state_t;

  state_t      state, state_nx;
  logic [15:0] burst_cnt;
  logic [7:0]  beat_cnt;
  logic [31:0] cur_addr;
  logic [31:0] beat_addr;
  logic        err_seen;
  logic        pass_q;
  logic [31:0] pattern;

  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        last_beat, last_burst;
  logic        bad_data, bad_last;
  logic [1:0]  err_inc;
  logic [31:0] err_at;
  logic [16:0] err_sum;

  // IDs and burst attributes never change
  assign awid    = AXI_ID;
  assign arid    = AXI_ID;
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign awlen   = LAST_BEAT;
  assign arlen   = LAST_BEAT;
  assign wstrb   = 4'hF;
  assign awaddr  = cur_addr;
  assign araddr  = cur_addr;
  assign wdata   = pattern;

  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign last_burst = (burst_cnt == LAST_BURST);
  assign wlast      = last_beat;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bready & bvalid;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rready & rvalid;

`ifdef MEMTEST_LFSR_EN
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  logic [31:0] lfsr, lfsr_nx;

  assign lfsr_nx = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  assign pattern = lfsr;

  // Reseeded at each phase so the read expectations replay the write stream
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if ((state == IDLE && start) || (b_hs && last_burst)) begin
      lfsr <= LFSR_SEED;
    end else if (w_hs || r_hs) begin
      lfsr <= lfsr_nx;
    end
  end
`else
  assign pattern = beat_addr ^ XOR_KEY;
`endif

  always_comb begin
    state_nx = state;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    bready   = 1'b0;
    arvalid  = 1'b0;
    rready   = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = WR_AW;
      end
      WR_AW: begin
        awvalid = 1'b1;
        if (awready) state_nx = WR_W;
      end
      WR_W: begin
        wvalid = 1'b1;
        if (wready && last_beat) state_nx = WR_B;
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) state_nx = last_burst ? RD_AR : WR_AW;
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) state_nx = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_nx = last_burst ? FIN : RD_AR;
      end
      FIN: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A read beat can cost two errors: bad data/response and a misplaced rlast
  assign bad_data = (rdata != pattern) || (rresp != 2'b00);
  assign bad_last = (rlast != last_beat);

  always_comb begin
    err_inc = 2'd0;
    err_at  = cur_addr;
    if (b_hs && bresp != 2'b00) err_inc = 2'd1;
    if (r_hs) begin
      err_at  = beat_addr;
      err_inc = {1'b0, bad_data} + {1'b0, bad_last};
    end
  end

  assign err_sum = {1'b0, err_count} + {15'd0, err_inc};

  // pass reads the live count during the done cycle, then holds
  assign pass = done ? (err_count == 16'd0) : pass_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      burst_cnt      <= 16'd0;
      beat_cnt       <= 8'd0;
      cur_addr       <= ADDR_BASE;
      beat_addr      <= ADDR_BASE;
      err_count      <= 16'd0;
      first_err_addr <= 32'd0;
      err_seen       <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      state <= state_nx;

      if (state == IDLE && start) begin
        burst_cnt      <= 16'd0;
        cur_addr       <= ADDR_BASE;
        beat_addr      <= ADDR_BASE;
        err_count      <= 16'd0;
        first_err_addr <= 32'd0;
        err_seen       <= 1'b0;
        pass_q         <= 1'b0;
      end

      if (aw_hs || ar_hs) begin
        beat_cnt  <= 8'd0;
        beat_addr <= cur_addr;
      end else if (w_hs || r_hs) begin
        beat_cnt  <= beat_cnt + 8'd1;
        beat_addr <= beat_addr + 32'd4;
      end

      if (b_hs && last_burst) begin
        cur_addr  <= ADDR_BASE;
        burst_cnt <= 16'd0;
      end else if (b_hs || (r_hs && rlast)) begin
        cur_addr  <= cur_addr + BURST_BYTES;
        burst_cnt <= burst_cnt + 16'd1;
      end

      if (err_inc != 2'd0) begin
        err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (!err_seen) begin
          err_seen       <= 1'b1;
          first_err_addr <= err_at;
        end
      end

      if (state == FIN) pass_q <= (err_count == 16'd0);
    end
  end

endmodule

// File: tb/tb_sdram_axi_memtest.sv
// Bench for sdram_axi_memtest: in-bench AXI slave with random stalls and fault injection,
// per-handshake checks against an address/beat-index pattern model, end-of-run result model.
module tb_sdram_axi_memtest;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          NB   = 4;
  localparam int          BL   = 8;
  localparam logic [3:0]  ID   = 4'h3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;
  logic        awvalid, awready = 1'b0;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid, wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = 2'b00;
  logic [3:0]  bid = ID;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0, rready;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00;
  logic [3:0]  rid = ID;
  logic        rlast = 1'b0;

  sdram_axi_memtest #(.ADDR_BASE(BASE), .NUM_BURSTS(NB), .BURST_LEN(BL), .AXI_ID(ID)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Pattern of the idx-th beat of a phase
  function automatic logic [31:0] pat(input int idx);
    logic [31:0] v;
`ifdef MEMTEST_LFSR_EN
    v = 32'h1;
    for (int i = 0; i < idx; i++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
`else
    v = (BASE + 32'(idx) * 32'd4) ^ 32'hA5A5_5A5A;
`endif
    return v;
  endfunction

  // Fault knobs
  bit          stall = 1'b0;
  logic [31:0] corrupt = 32'hFFFF_FFFF;
  int          b_bad = -1;
  int          r_bad = -1;

  // Expected final result: write-phase errors occur first, then read beats in address order
  task automatic model(output logic [15:0] e, output logic [31:0] f);
    logic [31:0] a;
    bit seen;
    e = 16'd0; f = 32'd0; seen = 1'b0;
    for (int b = 0; b < NB; b++)
      if (b == b_bad) begin
        e++;
        if (!seen) begin seen = 1'b1; f = BASE + 32'(b * BL * 4); end
      end
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < BL; k++) begin
        a = BASE + 32'((b * BL + k) * 4);
        if (a == corrupt || b == r_bad) begin
          e++;
          if (!seen) begin seen = 1'b1; f = a; end
        end
      end
  endtask

  // Slave state
  logic [31:0] mem [logic [31:0]];
  int          aw_n, w_n, b_n, ar_n, r_n, done_n;
  bit          w_act, b_pend, r_act, r_hold;
  int          w_beat, r_beat, r_burst;
  logic [31:0] w_addr, r_addr, ra;
  bit          aw_stall, w_stall, ar_stall;
  logic [31:0] aw_prev, w_prev, ar_prev;
  logic        wl_prev;
  logic [31:0] aw_cap [NB];
  logic [31:0] w_cap0, w_cap1;

  function automatic logic rnd_rdy();
    return stall ? 1'($urandom_range(1)) : 1'b1;
  endfunction

  // Slave + per-cycle compare; inputs change on negedge, DUT samples on posedge
  always @(negedge clk) begin
    if (reset || (start && !busy)) begin
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; done_n = 0;
      w_act = 0; b_pend = 0; r_act = 0; r_hold = 0;
      aw_stall = 0; w_stall = 0; ar_stall = 0;
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
    end else begin
      if (done) done_n++;
      if (aw_stall) begin
        chk("aw_hold_valid", 32'(awvalid), 1);
        chk("aw_hold_addr", awaddr, aw_prev);
      end
      if (w_stall) begin
        chk("w_hold_valid", 32'(wvalid), 1);
        chk("w_hold_data", wdata, w_prev);
        chk("w_hold_last", 32'(wlast), 32'(wl_prev));
      end
      if (ar_stall) begin
        chk("ar_hold_valid", 32'(arvalid), 1);
        chk("ar_hold_addr", araddr, ar_prev);
      end

      bvalid = 0;
      if (b_pend) begin
        bvalid = 1;
        bresp  = (b_n == b_bad) ? 2'b10 : 2'b00;
        if (bready) begin b_n++; b_pend = 0; end
      end

      rvalid = 0; rlast = 0;
      if (r_act && (r_hold || rnd_rdy())) begin
        rvalid = 1;
        ra     = r_addr + 32'(r_beat * 4);
        rdata  = mem.exists(ra) ? mem[ra] : 32'd0;
        if (ra == corrupt) rdata = rdata ^ 32'd1;
        rresp  = (r_burst == r_bad) ? 2'b10 : 2'b00;
        rlast  = (r_beat == BL - 1);
        if (rready) begin
          r_n++; r_beat++; r_hold = 0;
          if (r_beat == BL) r_act = 0;
        end else r_hold = 1;
      end

      awready = rnd_rdy();
      if (awvalid && awready) begin
        chk("aw_addr", awaddr, BASE + 32'(aw_n * BL * 4));
        chk("aw_len", 32'(awlen), BL - 1);
        chk("aw_burst", 32'(awburst), 1);
        chk("aw_id", 32'(awid), 32'(ID));
        chk("aw_order", 32'(w_act | b_pend), 0);
        if (aw_n < NB) aw_cap[aw_n] = awaddr;
        aw_n++; w_act = 1; w_beat = 0; w_addr = awaddr;
      end
      aw_stall = awvalid && !awready; aw_prev = awaddr;

      wready = rnd_rdy();
      if (wvalid && wready) begin
        chk("w_active", 32'(w_act), 1);
        chk("w_data", wdata, pat(w_n));
        chk("w_last", 32'(wlast), 32'(w_beat == BL - 1));
        chk("w_strb", 32'(wstrb), 32'hF);
        mem[w_addr + 32'(w_beat * 4)] = wdata;
        if (w_n == 0) w_cap0 = wdata;
        if (w_n == 1) w_cap1 = wdata;
        w_n++; w_beat++;
        if (w_beat == BL) begin w_act = 0; b_pend = 1; end
      end
      w_stall = wvalid && !wready; w_prev = wdata; wl_prev = wlast;

      arready = rnd_rdy();
      if (arvalid && arready) begin
        chk("ar_addr", araddr, BASE + 32'(ar_n * BL * 4));
        chk("ar_len", 32'(arlen), BL - 1);
        chk("ar_burst", 32'(arburst), 1);
        chk("ar_id", 32'(arid), 32'(ID));
        chk("ar_order", 32'(r_act), 0);
        r_burst = ar_n; ar_n++; r_act = 1; r_beat = 0; r_addr = araddr;
      end
      ar_stall = arvalid && !arready; ar_prev = araddr;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_awvalid"}, 32'(awvalid), 0);
    chk({tag, "_wvalid"}, 32'(wvalid), 0);
    chk({tag, "_arvalid"}, 32'(arvalid), 0);
    chk({tag, "_bready"}, 32'(bready), 0);
    chk({tag, "_rready"}, 32'(rready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // poke: pulse start during the read phase; rst_mid: reset during write beat 3
  task automatic run_test(input bit stl, input logic [31:0] cor, input int bb, input int rb,
                          input bit poke, input bit rst_mid);
    logic [15:0] e_err;
    logic [31:0] e_first;
    bit got;
    stall = stl; corrupt = cor; b_bad = bb; r_bad = rb;
    model(e_err, e_first);
    pulse_start();
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 1);
    chk("pass_cleared", 32'(pass), 0);
    chk("err_cleared", 32'(err_count), 0);
    if (rst_mid) begin
      got = 0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (w_n == 3) begin got = 1; break; end
      end
      chk("reach_beat3", 32'(got), 1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("mid_reset");
      chk("mid_reset_done", 32'(done), 0);
      return;
    end
    if (poke) begin
      got = 0;
      for (int i = 0; i < 5000; i++) begin
        @(negedge clk);
        if (r_n >= 20) begin got = 1; break; end
      end
      chk("reach_read", 32'(got), 1);
      pulse_start();
    end
    got = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk("done_seen", 32'(got), 1);
    if (!got) return;
    chk("done_busy", 32'(busy), 0);
    chk("pass", 32'(pass), 32'(e_err == 16'd0));
    chk("err_count", 32'(err_count), 32'(e_err));
    chk("first_err_addr", first_err_addr, e_first);
    chk("aw_count", aw_n, NB);
    chk("w_count", w_n, NB * BL);
    chk("b_count", b_n, NB);
    chk("ar_count", ar_n, NB);
    chk("r_count", r_n, NB * BL);
    @(negedge clk);
    chk("done_single", 32'(done_n), 1);
    chk("done_low", 32'(done), 0);
    chk("pass_held", 32'(pass), 32'(e_err == 16'd0));
    chk("err_held", 32'(err_count), 32'(e_err));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst");
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_first", first_err_addr, 0);

    // Clean zero-wait run, with literal pins on addresses and first data beats
    run_test(0, 32'hFFFF_FFFF, -1, -1, 0, 0);
    chk("lit_aw1", aw_cap[1], 32'h20);
    chk("lit_aw3", aw_cap[3], 32'h60);
`ifdef MEMTEST_LFSR_EN
    chk("lit_w0", w_cap0, 32'h0000_0001);
    chk("lit_w1", w_cap1, 32'h8020_0003);
`else
    chk("lit_w0", w_cap0, 32'hA5A5_5A5A);
    chk("lit_w1", w_cap1, 32'hA5A5_5A5E);
`endif
    chk("lit_pass1", 32'(pass), 1);

    // Corrupted beat at 0x44, plus a start pulse while busy that must be ignored
    run_test(0, 32'h44, -1, -1, 1, 0);
    chk("lit_err_corrupt", 32'(err_count), 1);
    chk("lit_first_corrupt", first_err_addr, 32'h44);

    // Bad bresp on burst 2 and bad rresp on burst 3
    run_test(0, 32'hFFFF_FFFF, 2, 3, 0, 0);
    chk("lit_err_resp", 32'(err_count), 9);
    chk("lit_first_resp", first_err_addr, 32'h40);

    // Random stalls, clean and with faults
    run_test(1, 32'hFFFF_FFFF, -1, -1, 0, 0);
    run_test(1, 32'h44, 2, 3, 0, 0);

    // Reset during write beat 3, then a full clean stalled run
    run_test(1, 32'hFFFF_FFFF, -1, -1, 0, 1);
    run_test(1, 32'hFFFF_FFFF, -1, -1, 0, 0);
    chk("lit_pass_after_reset", 32'(pass), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_axi_memtest.md
Name: sdram_axi_memtest

Overview:
- AXI4 master traffic generator/checker. Sits directly upstream of the AXI4-to-SDRAM controller and drives its AW/W/B/AR/R channels.
- On start it writes a deterministic pattern over a region using INCR bursts, reads the region back and compares every beat.
- Reports pass/fail, an error count and the first failing address. Used for board bring-up and regression of the SDRAM path.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of the first beat; must be 4-byte aligned.
- NUM_BURSTS, 64, bursts per phase, 1..65535.
- BURST_LEN, 16, beats per burst, 1..256; awlen/arlen = BURST_LEN-1.
- AXI_ID, 4'h3, constant value driven on awid/arid.

Ports:
- clk  input  1  system clock, shared with the SDRAM controller AXI side.
- reset  input  1  synchronous active-high reset.
- start  input  1  single-cycle pulse that launches a test; ignored while busy=1.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the read phase completes.
- pass  output  1  valid from done onward: 1 when err_count==0; cleared on the next accepted start.
- err_count  output  16  mismatches plus bad responses; saturates at 16'hFFFF.
- first_err_addr  output  32  byte address of the first failing beat; 0 if no error.
- awvalid/awready/awaddr[31:0]/awid[3:0]/awlen[7:0]/awburst[1:0]  out/in/out/out/out/out  AXI4 write address.
- wvalid/wready/wdata[31:0]/wstrb[3:0]/wlast  out/in/out/out/out  AXI4 write data.
- bvalid/bready/bresp[1:0]/bid[3:0]  in/out/in/in  AXI4 write response.
- arvalid/arready/araddr[31:0]/arid[3:0]/arlen[7:0]/arburst[1:0]  out/in/out/out/out/out  AXI4 read address.
- rvalid/rready/rdata[31:0]/rresp[1:0]/rid[3:0]/rlast  in/out/in/in/in/in  AXI4 read data.

Behaviour:
- Clock is clk. Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- While reset is high, all outputs are 0 next edge: valids, readies, busy, done, pass, err_count, first_err_addr. State goes to IDLE. A reset mid-burst abandons the transaction without draining it.
- Constant outputs: awburst = arburst = 2'b01 (INCR); wstrb = 4'hF; awid = arid = AXI_ID.
- FSM states: IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, FIN.
  - IDLE: start -> WR_AW. This clears err_count, first_err_addr and pass, sets burst counter=0 and cur_addr=ADDR_BASE, and loads the pattern generator.
  - WR_AW: awvalid=1 with awaddr=cur_addr. On awvalid&awready -> WR_W, beat counter=0.
  - WR_W: wvalid=1. Each wvalid&wready advances the beat counter and the pattern. wlast=1 when beat==BURST_LEN-1. On the last handshake -> WR_B.
  - WR_B: bready=1. On bvalid, bresp!=2'b00 counts one error at the burst address. Then cur_addr += BURST_LEN*4 and the burst counter increments.
    - If burst counter == NUM_BURSTS-1 -> RD_AR, with cur_addr=ADDR_BASE, burst counter=0 and the pattern reloaded.
    - Otherwise -> WR_AW.
  - RD_AR: arvalid=1 with araddr=cur_addr. On arvalid&arready -> RD_R.
  - RD_R: rready=1. Each rvalid beat is compared against the expected pattern, then the pattern and beat address advance.
    - One error per beat if rdata mismatches or rresp!=0; one extra error if rlast disagrees with beat==BURST_LEN-1.
    - Leaves on the beat with rlast=1, advancing as in WR_B. After the last burst -> FIN.
  - FIN: done=1 for one cycle, pass=(err_count==0), busy=0 -> IDLE.
- first_err_addr latches only on the first error after start.
- Error counting saturates at 16'hFFFF (no wrap).
- Handshake rules:
  - Valid and payload are held stable until the ready handshake.
  - At most one outstanding transaction; AW/W are strictly ordered.
  - bid/rid are not checked.
- Default pattern: data = beat byte address XOR 32'hA5A5_5A5A. The write and read phases generate identical sequences.
- Address arithmetic is 32-bit modulo and wraps silently past 32'hFFFF_FFFF. NUM_BURSTS=1 and BURST_LEN=1 are legal; wlast is then asserted on the single beat.

Optional Feature:
- Macro MEMTEST_LFSR_EN.
- Defined: the pattern is a 32-bit Galois LFSR (taps 32,22,2,1; seed 32'h0000_0001). It advances once per beat and is reseeded at the start of each phase, so read expectations equal write data.
- Undefined: the address-XOR pattern above; no LFSR register is synthesized.

Test Plan:
- NUM_BURSTS=4, BURST_LEN=8, ideal slave model with zero wait states, start pulse -> 4 AW bursts at 0x00,0x20,0x40,0x60 with awlen=7 and 32 W beats, then 4 AR bursts; done pulses once, pass=1, err_count=0.
- Same run, slave corrupts rdata of the beat at 0x44 (bit0 flipped) -> err_count=1, first_err_addr=0x44, pass=0.
- Slave returns bresp=2'b10 on burst 2 and rresp=2'b10 on all 8 beats of burst 3 -> err_count=9, first_err_addr=0x40.
- Random awready/wready/arready/rvalid stalls (50%) -> payloads stable while stalled, identical results to zero-wait run, exactly one handshake per beat.
- reset asserted during WR_W beat 3 -> next cycle all valids=0, busy=0; a new start runs a full clean test with pass=1.
- start pulsed while busy -> ignored, no counter reset; with MEMTEST_LFSR_EN defined, the first wdata beats are 0x00000001, 0x80200003.
